// File: rtl/stack_pkg.sv
// stack_pkg: shared types and default sizes for the operand-stack sequencer.
//   op_e    : 3-bit stack command opcode
//   state_e : sequencer phases (idle, register-file read, write-back, done)
package stack_pkg;

   localparam int unsigned DefDepth = 8;
   localparam int unsigned DefWidth = 8;

   typedef enum logic [2:0] {
      OpNop  = 3'd0,
      OpPush = 3'd1,
      OpPop  = 3'd2,
      OpAdd  = 3'd3,
      OpSub  = 3'd4,
      OpDup  = 3'd5,
      OpSwap = 3'd6,
      OpClr  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      StIdle,
      StRd,
      StWr,
      StDone
   } state_e;

endpackage

// File: rtl/stack_alu.sv
// stack_alu: combinational command evaluator for the operand stack.
//   in : op, a (TOS), b (NOS), imm, top (current), depth (current)
//   out: legal, write strobes/selects/data for ports a and b,
//        depth_nxt and top_nxt (unchanged when the command is illegal)
module stack_alu import stack_pkg::*; #(
   parameter  int unsigned DEPTH = DefDepth,
   parameter  int unsigned WIDTH = DefWidth,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  op_e              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] top,
   input  logic [AW:0]      depth,
   output logic             legal,
   output logic             wr_en_a,
   output logic             wr_en_b,
   output logic [AW-1:0]    wr_sel_a,
   output logic [AW-1:0]    wr_sel_b,
   output logic [WIDTH-1:0] wr_data_a,
   output logic [WIDTH-1:0] wr_data_b,
   output logic [AW:0]      depth_nxt,
   output logic [WIDTH-1:0] top_nxt
);

   localparam logic [AW:0] Full = (AW+1)'(DEPTH);
   localparam logic [AW:0] One  = (AW+1)'(1);
   localparam logic [AW:0] Two  = (AW+1)'(2);

   logic             has_one, has_two, has_room;
   logic [AW-1:0]    idx_tos, idx_nos, idx_new;
   logic [WIDTH-1:0] sum, diff;

   assign has_one  = depth >= One;
   assign has_two  = depth >= Two;
   assign has_room = depth < Full;
   // Entry indices wrap mod DEPTH; wrapped values only occur on illegal commands.
   assign idx_new  = depth[AW-1:0];
   assign idx_tos  = depth[AW-1:0] - AW'(1);
   assign idx_nos  = depth[AW-1:0] - AW'(2);
   assign sum      = b + a;
   assign diff     = b - a;

   always_comb begin
      legal     = 1'b1;
      wr_en_a   = 1'b0;
      wr_en_b   = 1'b0;
      wr_sel_a  = '0;
      wr_sel_b  = '0;
      wr_data_a = '0;
      wr_data_b = '0;
      depth_nxt = depth;
      top_nxt   = top;
      unique case (op)
         OpNop: ;
         OpPush: begin
            if (has_room) begin
               wr_en_a   = 1'b1;
               wr_sel_a  = idx_new;
               wr_data_a = imm;
               depth_nxt = depth + One;
               top_nxt   = imm;
            end else begin
               legal = 1'b0;
            end
         end
         OpPop: begin
            if (has_one) begin
               depth_nxt = depth - One;
               top_nxt   = (depth == One) ? '0 : b;
            end else begin
               legal = 1'b0;
            end
         end
         OpAdd, OpSub: begin
            if (has_two) begin
               wr_en_a   = 1'b1;
               wr_sel_a  = idx_nos;
               wr_data_a = (op == OpAdd) ? sum : diff;
               depth_nxt = depth - One;
               top_nxt   = (op == OpAdd) ? sum : diff;
            end else begin
               legal = 1'b0;
            end
         end
         OpDup: begin
            if (has_one && has_room) begin
               wr_en_a   = 1'b1;
               wr_sel_a  = idx_new;
               wr_data_a = a;
               depth_nxt = depth + One;
               top_nxt   = a;
            end else begin
               legal = 1'b0;
            end
         end
         OpSwap: begin
            if (has_two) begin
               wr_en_a   = 1'b1;
               wr_sel_a  = idx_nos;
               wr_data_a = a;
               wr_en_b   = 1'b1;
               wr_sel_b  = idx_tos;
               wr_data_b = b;
               top_nxt   = b;
            end else begin
               legal = 1'b0;
            end
         end
         OpClr: begin
            depth_nxt = '0;
            top_nxt   = '0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/stack_ctrl.sv
// stack_ctrl: sequences one stack command at a time over the shared register file.
//   cmd_valid/cmd_ready/cmd_op/cmd_imm : command handshake (ready only in idle)
//   done/err                           : one-cycle completion pulse, err valid with done
//   top/depth                          : registered top-of-stack and entry count
//   rf_re_* / rf_wr_*                  : register file read selects/data, write ports a/b
module stack_ctrl import stack_pkg::*; #(
   parameter  int unsigned DEPTH = DefDepth,
   parameter  int unsigned WIDTH = DefWidth,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  op_e              cmd_op,
   input  logic [WIDTH-1:0] cmd_imm,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] top,
   output logic [AW:0]      depth,
   output logic [AW-1:0]    rf_re_sel_a,
   output logic [AW-1:0]    rf_re_sel_b,
   input  logic [WIDTH-1:0] rf_re_data_a,
   input  logic [WIDTH-1:0] rf_re_data_b,
   output logic [AW-1:0]    rf_wr_sel_a,
   output logic [AW-1:0]    rf_wr_sel_b,
   output logic [WIDTH-1:0] rf_wr_data_a,
   output logic [WIDTH-1:0] rf_wr_data_b,
   output logic             rf_wr_en_a,
   output logic             rf_wr_en_b
);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] imm_q, imm_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] top_q, top_d;
   logic [AW:0]      depth_q, depth_d;
   logic             err_q, err_d;

   logic             alu_legal, alu_en_a, alu_en_b;
   logic [AW-1:0]    alu_sel_a, alu_sel_b;
   logic [WIDTH-1:0] alu_data_a, alu_data_b, alu_top;
   logic [AW:0]      alu_depth;

   stack_alu #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_alu (
      .op        (op_q),
      .a         (a_q),
      .b         (b_q),
      .imm       (imm_q),
      .top       (top_q),
      .depth     (depth_q),
      .legal     (alu_legal),
      .wr_en_a   (alu_en_a),
      .wr_en_b   (alu_en_b),
      .wr_sel_a  (alu_sel_a),
      .wr_sel_b  (alu_sel_b),
      .wr_data_a (alu_data_a),
      .wr_data_b (alu_data_b),
      .depth_nxt (alu_depth),
      .top_nxt   (alu_top)
   );

   // Gating with rst_n keeps a command caught by reset from handshaking or writing.
   assign cmd_ready = rst_n && (state_q == StIdle);
   assign done      = rst_n && (state_q == StDone);
   assign err       = done && err_q;
   assign top       = top_q;
   assign depth     = depth_q;

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      imm_d        = imm_q;
      a_d          = a_q;
      b_d          = b_q;
      top_d        = top_q;
      depth_d      = depth_q;
      err_d        = err_q;
      rf_re_sel_a  = '0;
      rf_re_sel_b  = '0;
      rf_wr_sel_a  = '0;
      rf_wr_sel_b  = '0;
      rf_wr_data_a = '0;
      rf_wr_data_b = '0;
      rf_wr_en_a   = 1'b0;
      rf_wr_en_b   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid && cmd_ready) begin
               op_d    = cmd_op;
               imm_d   = cmd_imm;
               state_d = StRd;
            end
         end
         StRd: begin
            rf_re_sel_a = depth_q[AW-1:0] - AW'(1);
            rf_re_sel_b = depth_q[AW-1:0] - AW'(2);
            a_d         = rf_re_data_a;
            b_d         = rf_re_data_b;
            state_d     = StWr;
         end
         StWr: begin
            rf_wr_en_a   = alu_en_a && rst_n;
            rf_wr_en_b   = alu_en_b && rst_n;
            rf_wr_sel_a  = alu_sel_a;
            rf_wr_sel_b  = alu_sel_b;
            rf_wr_data_a = alu_data_a;
            rf_wr_data_b = alu_data_b;
            depth_d      = alu_depth;
            top_d        = alu_top;
            err_d        = !alu_legal;
            state_d      = StDone;
         end
         StDone: begin
            err_d   = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         op_q    <= OpNop;
         imm_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         top_q   <= '0;
         depth_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         imm_q   <= imm_d;
         a_q     <= a_d;
         b_q     <= b_d;
         top_q   <= top_d;
         depth_q <= depth_d;
         err_q   <= err_d;
      end
   end

endmodule
